// File: rtl/hb_pkg.sv
// Shared heartbeat/CH-advertisement definitions, used by both the transmit and receive sides.
package hb_pkg;

  localparam int          WORD_WIDTH   = 16;
  localparam logic [15:0] PKT_TYPE_HB  = 16'h00A5;
  localparam logic [15:0] HOPS_UNKNOWN = 16'hFFFF;
  localparam logic [15:0] HOPS_MAX     = 16'hFFFE;
  localparam logic [15:0] Q_ONE        = 16'h4000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } hb_state_t;

  typedef enum logic [2:0] {
    W_TYPE = 3'd0,
    W_ID   = 3'd1,
    W_CH   = 3'd2,
    W_HOP  = 3'd3,
    W_Q    = 3'd4
  } hb_word_t;

  // A member advertises its CH one hop further out; HOPS_UNKNOWN stays reserved.
  function automatic logic [WORD_WIDTH-1:0] relay_hops(input logic [WORD_WIDTH-1:0] h);
    return (h >= HOPS_MAX) ? HOPS_MAX : h + 16'd1;
  endfunction

endpackage

// File: rtl/hb_gap_timer.sv
// Loadable down-counter with zero flag; timing of the idle gap between packet copies.
// Counts down one per dec cycle and stops at zero; clr has priority over load.
module hb_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hb_tx.sv
// Heartbeat/CH announcement transmitter: snapshots the CH view on start, sends REPEAT 5-word copies.
// First word 2 cycles after start; valid/ready stream, words held stable while tx_ready is low.
module hb_tx
  import hb_pkg::*;
#(
  parameter int REPEAT     = 3,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_HBTX,
  input  logic                  HB_reset,
  input  logic                  is_CH,
  input  logic [WORD_WIDTH-1:0] my_ID,
  input  logic [WORD_WIDTH-1:0] my_QValue,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done,
  output logic                  drop
);

  localparam int          GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [3:0]  REP_L = 4'(REPEAT);

  hb_state_t             state_q, state_d;
  hb_word_t              idx_q, idx_d;
  logic [3:0]            copies_q, copies_d;
  logic                  drop_q, drop_d;
  logic                  capture, gap_load, gap_dec, gap_zero;
  logic [WORD_WIDTH-1:0] id_q, ch_q, hop_q, qv_q;
  logic [WORD_WIDTH-1:0] word_d;

  hb_gap_timer #(.W(GW)) u_gap (
    .clk      (clk),
    .rst_n    (nrst),
    .clr      (HB_reset),
    .load     (gap_load),
    .load_val (GW'(GAP_CYCLES - 1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    copies_d = copies_q;
    drop_d   = drop_q;
    capture  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    if (HB_reset) begin
      state_d  = ST_IDLE;
      idx_d    = W_TYPE;
      copies_d = '0;
      drop_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (en_HBTX) state_d = ST_LOAD;
        ST_LOAD: begin
          capture  = 1'b1;
          idx_d    = W_TYPE;
          copies_d = '0;
          if (!is_CH && (hopsFromCH == HOPS_UNKNOWN)) begin
            drop_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          // tx_valid is always high in SEND, so tx_ready alone marks a transfer
          if (tx_ready) begin
            if (idx_q == W_Q) begin
              copies_d = copies_q + 4'd1;
              idx_d    = W_TYPE;
              if (copies_q + 4'd1 == REP_L) begin
                state_d = ST_FIN;
              end else begin
                state_d  = ST_GAP;
                gap_load = 1'b1;
              end
            end else begin
              idx_d = hb_word_t'(idx_q + 3'd1);
            end
          end
        end
        ST_GAP: begin
          if (gap_zero) begin
            state_d = ST_SEND;
            idx_d   = W_TYPE;
          end else begin
            gap_dec = 1'b1;
          end
        end
        ST_FIN: begin
          state_d  = ST_IDLE;
          copies_d = '0;
          drop_d   = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    word_d = '0;
    case (idx_d)
      W_TYPE:  word_d = PKT_TYPE_HB;
      W_ID:    word_d = id_q;
      W_CH:    word_d = ch_q;
      W_HOP:   word_d = hop_q;
      W_Q:     word_d = qv_q;
      default: word_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      idx_q    <= W_TYPE;
      copies_q <= '0;
      drop_q   <= 1'b0;
      id_q     <= '0;
      ch_q     <= '0;
      hop_q    <= '0;
      qv_q     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      copies_q <= copies_d;
      drop_q   <= drop_d;
      if (capture) begin
        id_q  <= my_ID;
        ch_q  <= is_CH ? my_ID : chosenCH;
        hop_q <= is_CH ? 16'd1 : relay_hops(hopsFromCH);
        qv_q  <= my_QValue;
      end
      // Outputs follow the next state; word 0 is a constant, so the snapshot landing on the same edge is safe.
      tx_valid <= (state_d == ST_SEND);
      tx_last  <= (state_d == ST_SEND) && (idx_d == W_Q);
      tx_data  <= (state_d == ST_SEND) ? word_d : '0;
      busy     <= (state_d != ST_IDLE);
      done     <= (state_d == ST_FIN);
      drop     <= (state_d == ST_FIN) && drop_d;
    end
  end

endmodule

// File: tb/tb_hb_tx.sv
// Bench for hb_tx: vector table, random member/CH starts against a packet model, and abort/reset sequences.
module tb_hb_tx;

  localparam int GAP = 8;

  typedef logic [4:0][15:0] pkt_t;

  typedef struct {
    bit          sel;
    bit          ch;
    logic [15:0] id;
    logic [15:0] cid;
    logic [15:0] hops;
    logic [15:0] q;
    pkt_t        w;
    bit          drp;
    int          mode;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en_HBTX = 1'b0;
  logic        HB_reset = 1'b0;
  logic        is_CH = 1'b0;
  logic [15:0] my_ID = '0, my_QValue = '0, chosenCH = '0, hopsFromCH = '0;
  logic        tx_ready = 1'b1;
  logic        sel = 1'b0;

  logic [15:0] d3, d1;
  logic        v3, l3, b3, dn3, dr3, v1, l1, b1, dn1, dr1;
  logic [15:0] m_data;
  logic        m_valid, m_last, m_busy, m_done, m_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hb_tx #(.REPEAT(3), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .nrst(nrst), .en_HBTX(en_HBTX), .HB_reset(HB_reset), .is_CH(is_CH),
    .my_ID(my_ID), .my_QValue(my_QValue), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
    .tx_ready(tx_ready), .tx_data(d3), .tx_valid(v3), .tx_last(l3), .busy(b3),
    .done(dn3), .drop(dr3)
  );

  hb_tx #(.REPEAT(1), .GAP_CYCLES(GAP)) u_one (
    .clk(clk), .nrst(nrst), .en_HBTX(en_HBTX), .HB_reset(HB_reset), .is_CH(is_CH),
    .my_ID(my_ID), .my_QValue(my_QValue), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
    .tx_ready(tx_ready), .tx_data(d1), .tx_valid(v1), .tx_last(l1), .busy(b1),
    .done(dn1), .drop(dr1)
  );

  assign m_data  = sel ? d1  : d3;
  assign m_valid = sel ? v1  : v3;
  assign m_last  = sel ? l1  : l3;
  assign m_busy  = sel ? b1  : b3;
  assign m_done  = sel ? dn1 : dn3;
  assign m_drop  = sel ? dr1 : dr3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [15:0] a, b, c, d, e);
    pkt_t p;
    p[0] = a; p[1] = b; p[2] = c; p[3] = d; p[4] = e;
    return p;
  endfunction

  // Packet model computed straight from the field rules.
  function automatic void model(input bit ch, input logic [15:0] id, cid, hops, q,
                                output pkt_t w, output bit drp);
    int h;
    drp  = 1'b0;
    w[0] = 16'h00A5;
    w[1] = id;
    w[4] = q;
    if (ch) begin
      w[2] = id;
      w[3] = 16'd1;
    end else begin
      w[2] = cid;
      if (hops == 16'hFFFF) drp = 1'b1;
      h = int'(hops) + 1;
      if (h > 65534) h = 65534;
      w[3] = 16'(h);
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((b1 || b3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle before start", {31'd0, (b1 || b3)}, 32'd0);
  endtask

  // mode 0: ready high; 1: random ready; 2: 4-cycle stall at word 2; 3: ready high plus restarts while busy
  task automatic run_capture(input pkt_t ew, input bit exp_drop, input int mode, input string tag);
    logic [15:0] got[$];
    bit          lastf[$];
    int          rises[$];
    int          lastks[$];
    int          rep = sel ? 1 : 3;
    int          done_cnt = 0, done_k = -1, drop_seen = 0, stall_err = 0, stall_cyc = 0;
    int          stall_bad = 0, first_v = -1, after = 0, stall_left = 4, n;
    bit          prev_valid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [15:0] prev_data = '0;
    wait_idle();
    @(negedge clk);
    en_HBTX  = 1'b1;
    tx_ready = 1'b1;
    for (int k = 1; k < 600 && after < 4; k++) begin
      @(negedge clk);
      en_HBTX = 1'b0;
      if (mode == 3 && (k == 4 || k == 12)) begin
        en_HBTX  = 1'b1;
        my_ID    = 16'($urandom);
        chosenCH = 16'($urandom);
      end
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
        stall_err++;
      if (m_valid && !prev_valid) rises.push_back(k);
      if (m_valid && first_v < 0) first_v = k;
      if (m_done) begin
        done_cnt++;
        done_k    = k;
        drop_seen = int'(m_drop);
      end else if (m_drop) begin
        drop_seen = 2;
      end
      if (done_cnt > 0) after++;
      case (mode)
        1: tx_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (m_valid && got.size() == 2 && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
            stall_cyc++;
            if (m_data !== ew[2]) stall_bad++;
          end else begin
            tx_ready = 1'b1;
          end
        end
        default: tx_ready = 1'b1;
      endcase
      if (m_valid && tx_ready) begin
        got.push_back(m_data);
        lastf.push_back(m_last);
        if (m_last) lastks.push_back(k);
      end
      prev_stall = m_valid && !tx_ready;
      prev_valid = m_valid;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    tx_ready = 1'b1;
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " drop"}, drop_seen, {31'd0, exp_drop});
    if (exp_drop) begin
      check({tag, " words on drop"}, got.size(), 0);
      check({tag, " drop timing"}, done_k, 2);
      check({tag, " valid on drop"}, first_v, -1);
    end else begin
      check({tag, " word count"}, got.size(), 5 * rep);
      n = (got.size() < 5 * rep) ? got.size() : 5 * rep;
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s word %0d", tag, i), got[i], ew[i % 5]);
        check($sformatf("%s last %0d", tag, i), lastf[i], (i % 5) == 4);
      end
      check({tag, " first valid"}, first_v, 2);
      check({tag, " copies"}, rises.size(), rep);
      if (lastks.size() > 0) check({tag, " done timing"}, done_k, lastks[lastks.size()-1] + 1);
      for (int i = 0; i + 1 < rises.size() && i < lastks.size(); i++)
        check($sformatf("%s gap %0d", tag, i), rises[i+1] - lastks[i], GAP + 1);
      check({tag, " hold under stall"}, stall_err, 0);
      if (mode == 2) begin
        check({tag, " stall cycles"}, stall_cyc, 4);
        check({tag, " stalled word"}, stall_bad, 0);
      end
    end
  endtask

  task automatic apply(input bit ch, input logic [15:0] id, cid, hops, q);
    is_CH = ch; my_ID = id; chosenCH = cid; hopsFromCH = hops; my_QValue = q;
  endtask

  vec_t tbl[8];

  initial begin
    pkt_t        ew;
    bit          drp;
    int          n, dcnt;
    bit          hit;
    logic [15:0] hops;

    tbl[0] = '{1'b1, 1'b1, 16'd23, 16'd0,  16'd0,     16'h3000, mk(16'h00A5, 16'h0017, 16'h0017, 16'h0001, 16'h3000), 1'b0, 0};
    tbl[1] = '{1'b0, 1'b0, 16'd45, 16'd12, 16'd1,     16'h2000, mk(16'h00A5, 16'h002D, 16'h000C, 16'h0002, 16'h2000), 1'b0, 0};
    tbl[2] = '{1'b0, 1'b0, 16'd45, 16'd12, 16'd1,     16'h2000, mk(16'h00A5, 16'h002D, 16'h000C, 16'h0002, 16'h2000), 1'b0, 2};
    tbl[3] = '{1'b0, 1'b0, 16'd7,  16'd9,  16'hFFFF,  16'h4000, mk(16'h00A5, 16'h0007, 16'h0009, 16'hFFFE, 16'h4000), 1'b1, 0};
    tbl[4] = '{1'b0, 1'b0, 16'd7,  16'd9,  16'hFFFE,  16'h4000, mk(16'h00A5, 16'h0007, 16'h0009, 16'hFFFE, 16'h4000), 1'b0, 0};
    tbl[5] = '{1'b0, 1'b0, 16'd7,  16'd9,  16'hFFFD,  16'h1234, mk(16'h00A5, 16'h0007, 16'h0009, 16'hFFFE, 16'h1234), 1'b0, 0};
    tbl[6] = '{1'b1, 1'b1, 16'd99, 16'd5,  16'hFFFF,  16'h0800, mk(16'h00A5, 16'h0063, 16'h0063, 16'h0001, 16'h0800), 1'b0, 0};
    tbl[7] = '{1'b0, 1'b0, 16'd45, 16'd12, 16'd1,     16'h2000, mk(16'h00A5, 16'h002D, 16'h000C, 16'h0002, 16'h2000), 1'b0, 3};

    // reset state
    #2;
    check("reset data", d3, 16'h0);
    check("reset valid/last", {v3, l3, v1, l1}, 4'h0);
    check("reset busy/done/drop", {b3, dn3, dr3, b1, dn1, dr1}, 6'h0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].sel;
      apply(tbl[i].ch, tbl[i].id, tbl[i].cid, tbl[i].hops, tbl[i].q);
      run_capture(tbl[i].w, tbl[i].drp, tbl[i].mode, $sformatf("vec%0d", i));
    end

    // abort during word 3 of copy 2
    sel = 1'b0;
    wait_idle();
    apply(1'b0, 16'd45, 16'd12, 16'd1, 16'h2000);
    @(negedge clk);
    en_HBTX = 1'b1;
    n = 0;
    hit = 1'b0;
    for (int k = 1; k < 60 && !hit; k++) begin
      @(negedge clk);
      en_HBTX = 1'b0;
      if (m_valid && n == 8) begin
        check("abort word", m_data, 16'h0002);
        HB_reset = 1'b1;
        hit = 1'b1;
      end else if (m_valid) begin
        n++;
      end
    end
    check("abort reached", {31'd0, hit}, 32'd1);
    @(negedge clk);
    HB_reset = 1'b0;
    check("abort valid", m_valid, 1'b0);
    check("abort busy", m_busy, 1'b0);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_done || m_valid) dcnt++;
      @(negedge clk);
    end
    check("abort silent", dcnt, 0);
    run_capture(mk(16'h00A5, 16'h002D, 16'h000C, 16'h0002, 16'h2000), 1'b0, 0, "after abort");

    // HB_reset and en_HBTX together: no start
    wait_idle();
    en_HBTX = 1'b1;
    HB_reset = 1'b1;
    @(negedge clk);
    en_HBTX = 1'b0;
    HB_reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_busy || m_valid || m_done) dcnt++;
    end
    check("reset beats start", dcnt, 0);

    // async reset mid-packet
    @(negedge clk);
    en_HBTX = 1'b1;
    @(negedge clk);
    en_HBTX = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("async clear valid/busy", {v3, b3, v1, b1}, 4'h0);
    check("async clear data", d3, 16'h0);
    @(negedge clk);
    nrst = 1'b1;

    // random starts against the model
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 5))
        0:       hops = 16'hFFFF;
        1:       hops = 16'hFFFE;
        2:       hops = 16'hFFFD;
        default: hops = 16'($urandom_range(0, 30));
      endcase
      sel = ($urandom_range(0, 3) == 0);
      apply(1'($urandom), 16'($urandom), 16'($urandom), hops, 16'($urandom));
      model(is_CH, my_ID, chosenCH, hopsFromCH, my_QValue, ew, drp);
      run_capture(ew, drp, 1, $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hb_tx.md
Name: hb_tx

Overview:
- Heartbeat/cluster-head announcement transmitter: the sending end of the CH-advertisement interface whose receive side picks `chosenCH`/`hopsFromCH` from incoming (`fCH_ID`, `fCH_Hops`, `fCH_QValue`) triples.
- On a start pulse it snapshots the node's CH view and serializes a 5-word packet to the radio/MAC over a valid/ready word stream.
- The packet is repeated REPEAT times with an idle gap between copies.
- A CH advertises itself. A member node re-advertises its chosen CH one hop further out.

Parameters:
- WORD_WIDTH, 16, width of every data word and field.
- PKT_TYPE_HB, 16'h00A5, header word identifying a heartbeat/CH packet.
- REPEAT, 3, number of packet copies per start (1..15).
- GAP_CYCLES, 8, idle cycles between copies (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en_HBTX  in  1  start pulse; sampled only in IDLE.
- HB_reset  in  1  synchronous abort/clear; highest priority after nrst.
- is_CH  in  1  node is a cluster head this round.
- my_ID  in  16  own node ID.
- my_QValue  in  16  own Q-value, unsigned Q2.14 (16'h4000 = 1.0).
- chosenCH  in  16  currently selected CH ID (from the receive side).
- hopsFromCH  in  16  hops to that CH; 16'hFFFF = none known.
- tx_ready  in  1  downstream accepts a word this cycle.
- tx_data  out  16  current word.
- tx_valid  out  1  tx_data is valid.
- tx_last  out  1  marks word 4 of the packet.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final copy completes or is dropped.
- drop  out  1  one-cycle pulse, coincident with done, when the packet was suppressed.

Behaviour:
- Reset (nrst low, async): state IDLE; tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, drop=0; snapshot registers and counters cleared.
- Packet format, word index 0..4:
  - word 0: PKT_TYPE_HB
  - word 1: my_ID
  - word 2: CH field
  - word 3: hop field
  - word 4: Q field
- Field values, all captured at start:
  - is_CH=1: CH field = my_ID, hop field = 1, Q field = my_QValue.
  - is_CH=0: CH field = chosenCH, hop field = hopsFromCH+1 saturating at 16'hFFFE, Q field = my_QValue.
  - Later input changes do not affect an in-flight packet.
- FSM states: IDLE, LOAD, SEND, GAP, FIN.
  - IDLE: en_HBTX=1 -> LOAD.
  - LOAD, 1 cycle: capture fields.
    - If is_CH=0 and hopsFromCH=16'hFFFF -> FIN with drop flagged.
    - Otherwise word index=0, copy count=0 -> SEND.
  - SEND: tx_valid=1; tx_data = word[index]; tx_last=1 when index=4.
    - A word transfers when tx_valid and tx_ready are both high.
    - On transfer with index<4: index++.
    - On transfer with index=4: copy count++. If copy count reaches REPEAT -> FIN; otherwise -> GAP.
    - With tx_ready low, tx_data, tx_valid and tx_last hold stable (AXI-style).
    - tx_valid never deasserts before the transfer completes.
  - GAP: tx_valid=0 for exactly GAP_CYCLES cycles, then index=0 -> SEND.
  - FIN, 1 cycle: done=1 (plus drop=1 if flagged) -> IDLE.
- Outputs are registered. The first word appears the cycle after LOAD, i.e. tx_valid rises 2 cycles after the en_HBTX sample edge.
- Minimum packet time is 5 cycles with tx_ready held high.
- en_HBTX while busy: ignored, not queued.
- HB_reset=1 in any state:
  - Next edge -> IDLE, tx_valid=0, counters cleared, no done pulse.
  - This applies even mid-packet; the partial packet is abandoned.
- HB_reset and en_HBTX in the same cycle: HB_reset wins; no start.
- nrst mid-packet: immediate async clear, same values as reset.

Decomposition:
- Shared package hb_pkg holds:
  - WORD_WIDTH
  - PKT_TYPE_HB
  - HOPS_UNKNOWN = 16'hFFFF
  - HOPS_MAX = 16'hFFFE
  - Q_ONE = 16'h4000
  - the FSM state enum
  - the packet word-index enum
  - These are reused by the receive side.
- One natural sub-module: hb_gap_timer, a loadable down-counter with a zero flag used for GAP.

Test Plan:
- CH advertise: is_CH=1, my_ID=23, my_QValue=16'h3000, REPEAT=1, tx_ready=1, pulse en_HBTX.
  - Expect words 00A5, 0017, 0017, 0001, 3000 on 5 consecutive cycles, starting 2 cycles after the pulse.
  - tx_last only on 3000; done 1 cycle later.
- Member relay: is_CH=0, my_ID=45, chosenCH=12, hopsFromCH=1, my_QValue=16'h2000, REPEAT=3.
  - Expect 3 packets of 00A5, 002D, 000C, 0002, 2000.
  - Exactly 8 idle cycles between packets; single done after the third.
- Backpressure: hold tx_ready=0 for 4 cycles at word 2.
  - tx_data=000C and tx_valid stay stable throughout.
  - Sequence resumes without loss or duplication.
- Drop and saturation:
  - hopsFromCH=FFFF -> no tx_valid; done and drop pulse together 2 cycles after start.
  - hopsFromCH=FFFE -> hop word = FFFE.
- Abort: assert HB_reset during word 3 of copy 2.
  - Expect tx_valid=0 next cycle, busy=0, no done.
  - A new en_HBTX then yields a full fresh sequence.
- Start ignored while busy: en_HBTX pulses mid-packet and during GAP with changed my_ID.
  - Output packets keep the originally snapshotted values; only one done.
